// File: rtl/zverif_loader.sv
// Boot-image loader: takes a stream of 32-bit words, writes them through an
// AXI-lite write port into RAM port B, then releases the CPU from reset.
module zverif_loader #(
   parameter int ADDR_WIDTH      = 17,
   parameter int MAX_COUNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_addr,
   input  logic [31:0]                in_data,
   input  logic                       in_last,
   output logic [ADDR_WIDTH-1:0]      m_awaddr,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   output logic [31:0]                m_wdata,
   output logic [3:0]                 m_wstrb,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   input  logic                       m_bvalid,
   output logic                       m_bready,
   input  logic [1:0]                 m_bresp,
   output logic                       cpu_resetn,
   output logic                       done,
   output logic                       err,
   output logic [MAX_COUNT_WIDTH-1:0] word_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      RESP  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     next_state_s;
   logic [ADDR_WIDTH-1:0]      addr_r;
   logic [31:0]                data_r;
   logic                       last_r;
   logic                       aw_done_r;
   logic                       w_done_r;
   logic                       aw_done_s;
   logic                       w_done_s;
   logic                       in_ready_r;
   logic                       awvalid_r;
   logic                       wvalid_r;
   logic                       bready_r;
   logic                       done_r;
   logic                       cpu_resetn_r;
   logic                       err_r;
   logic [MAX_COUNT_WIDTH-1:0] word_count_r;
   logic                       in_ready_s;
   logic                       awvalid_s;
   logic                       wvalid_s;
   logic                       bready_s;
   logic                       done_s;
   logic                       accept_s;
   logic                       word_ok_s;
   logic                       aw_hs_s;
   logic                       w_hs_s;
   logic                       b_hs_s;

   // A load word is usable only if word aligned and inside the RAM window.
   function automatic logic addr_ok(input logic [31:0] addr);
      addr_ok = (addr[1:0] == 2'b00) && ((addr >> ADDR_WIDTH) == 32'd0);
   endfunction

   assign accept_s  = in_valid && in_ready_r;
   assign word_ok_s = addr_ok(in_addr);
   assign aw_hs_s   = awvalid_r && m_awready;
   assign w_hs_s    = wvalid_r && m_wready;
   assign b_hs_s    = (state_r == RESP) && m_bvalid;

   // Track AW and W completion independently so either may finish first.
   always_comb begin
      aw_done_s = 1'b0;
      w_done_s  = 1'b0;
      if (state_r == WRITE) begin
         aw_done_s = aw_done_r || aw_hs_s;
         w_done_s  = w_done_r || w_hs_s;
      end else begin
         aw_done_s = 1'b0;
         w_done_s  = 1'b0;
      end
   end

   // State register and per-transfer handshake flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r   <= IDLE;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         aw_done_r <= aw_done_s;
         w_done_r  <= w_done_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (word_ok_s) begin
                  next_state_s = WRITE;
               end else if (in_last) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         WRITE: begin
            if (aw_done_s && w_done_s) begin
               next_state_s = RESP;
            end else begin
               next_state_s = WRITE;
            end
         end
         RESP: begin
            if (m_bvalid) begin
               next_state_s = last_r ? DONE : IDLE;
            end else begin
               next_state_s = RESP;
            end
         end
         DONE:    next_state_s = DONE;
         default: next_state_s = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so their registers line up with state_r.
   always_comb begin
      in_ready_s = (next_state_s == IDLE);
      awvalid_s  = (next_state_s == WRITE) && !aw_done_s;
      wvalid_s   = (next_state_s == WRITE) && !w_done_s;
      bready_s   = (next_state_s == RESP);
      done_s     = (next_state_s == DONE);
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         in_ready_r   <= 1'b0;
         awvalid_r    <= 1'b0;
         wvalid_r     <= 1'b0;
         bready_r     <= 1'b0;
         done_r       <= 1'b0;
         cpu_resetn_r <= 1'b0;
      end else begin
         in_ready_r   <= in_ready_s;
         awvalid_r    <= awvalid_s;
         wvalid_r     <= wvalid_s;
         bready_r     <= bready_s;
         done_r       <= done_s;
         cpu_resetn_r <= done_s;
      end
   end

   // Latched word plus sticky error and saturating success counter.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_r       <= {ADDR_WIDTH{1'b0}};
         data_r       <= 32'd0;
         last_r       <= 1'b0;
         err_r        <= 1'b0;
         word_count_r <= {MAX_COUNT_WIDTH{1'b0}};
      end else begin
         if (accept_s) begin
            addr_r <= in_addr[ADDR_WIDTH-1:0];
            data_r <= in_data;
            last_r <= in_last;
         end
         if ((accept_s && !word_ok_s) || (b_hs_s && (m_bresp != 2'b00))) begin
            err_r <= 1'b1;
         end
         if (b_hs_s && (m_bresp == 2'b00) && !(&word_count_r)) begin
            word_count_r <= word_count_r + MAX_COUNT_WIDTH'(1);
         end
      end
   end

   assign in_ready   = in_ready_r;
   assign m_awaddr   = addr_r;
   assign m_awvalid  = awvalid_r;
   assign m_wdata    = data_r;
   assign m_wstrb    = 4'hF;
   assign m_wvalid   = wvalid_r;
   assign m_bready   = bready_r;
   assign cpu_resetn = cpu_resetn_r;
   assign done       = done_r;
   assign err        = err_r;
   assign word_count = word_count_r;

endmodule

// File: tb/tb_zverif_loader.sv
// Randomized bench for zverif_loader: a queue-based model of the image load
// predicts writes, handshake flags, error and word count every cycle.
module tb_zverif_loader;
   localparam int AW = 17;
   localparam int CW = 3;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } word_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_addr;
   logic [31:0]   in_data;
   logic          in_last;
   logic [AW-1:0] m_awaddr;
   logic          m_awvalid;
   logic          m_awready;
   logic [31:0]   m_wdata;
   logic [3:0]    m_wstrb;
   logic          m_wvalid;
   logic          m_wready;
   logic          m_bvalid;
   logic          m_bready;
   logic [1:0]    m_bresp;
   logic          cpu_resetn;
   logic          done;
   logic          err;
   logic [CW-1:0] word_count;

   always #5 clk = ~clk;

   zverif_loader #(.ADDR_WIDTH(AW), .MAX_COUNT_WIDTH(CW)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_data(in_data), .in_last(in_last),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .cpu_resetn(cpu_resetn), .done(done), .err(err), .word_count(word_count)
   );

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   word_t img_q[$];
   word_t exp_q[$];
   int    img_idx;
   bit    aw_seen, w_seen, pending, exp_done, exp_err;
   int    exp_cnt;
   int    aw_pct, w_pct, b_pct, err_pct, spur_pct, in_pct, w_block;
   int    first_acc, done_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit word_ok(input logic [31:0] a);
      return (a % 32'd4 == 32'd0) && (a < (32'd1 << AW));
   endfunction

   task automatic model_reset();
      exp_q.delete();
      aw_seen = 1'b0; w_seen = 1'b0; pending = 1'b0;
      exp_done = 1'b0; exp_err = 1'b0; exp_cnt = 0;
      first_acc = -1; done_cyc = -1; w_block = 0;
   endtask

   task automatic set_slave(input int aw, input int w, input int b, input int e, input int sp, input int iv);
      aw_pct = aw; w_pct = w; b_pct = b; err_pct = e; spur_pct = sp; in_pct = iv;
   endtask

   task automatic check_rst_values(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_awvalid"}, 32'(m_awvalid), 32'd0);
      check({tag, "_wvalid"}, 32'(m_wvalid), 32'd0);
      check({tag, "_bready"}, 32'(m_bready), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_word_count"}, 32'(word_count), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      in_valid = 1'b0; in_addr = 32'd0; in_data = 32'd0; in_last = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
      repeat (2) begin
         @(negedge clk);
         check_rst_values("rst");
      end
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic add_word(input logic [31:0] a, input logic [31:0] d, input logic l);
      word_t w;
      w.addr = a; w.data = d; w.last = l;
      img_q.push_back(w);
   endtask

   // One clock: drive stimulus at negedge, compare against the model, advance the model.
   task automatic tick();
      word_t w;
      @(negedge clk);
      cyc++;
      if (img_idx < img_q.size()) begin
         in_valid = ($urandom_range(0, 99) < in_pct);
         in_addr  = img_q[img_idx].addr;
         in_data  = img_q[img_idx].data;
         in_last  = img_q[img_idx].last;
      end else begin
         in_valid = 1'b1;
         in_addr  = $urandom;
         in_data  = $urandom;
         in_last  = 1'($urandom_range(0, 1));
      end
      m_awready = ($urandom_range(0, 99) < aw_pct);
      m_wready  = (w_block > 0) ? 1'b0 : ($urandom_range(0, 99) < w_pct);
      if (pending) begin
         m_bvalid = ($urandom_range(0, 99) < b_pct);
         m_bresp  = ($urandom_range(0, 99) < err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
      end else begin
         m_bvalid = ($urandom_range(0, 99) < spur_pct);
         m_bresp  = 2'($urandom_range(0, 3));
      end
      #1;
      if (done && done_cyc < 0) done_cyc = cyc;
      check("in_ready", 32'(in_ready), 32'(!exp_done && exp_q.size() == 0));
      check("awvalid", 32'(m_awvalid), 32'(exp_q.size() > 0 && !aw_seen && !pending));
      check("wvalid", 32'(m_wvalid), 32'(exp_q.size() > 0 && !w_seen && !pending));
      check("bready", 32'(m_bready), 32'(pending));
      check("done", 32'(done), 32'(exp_done));
      check("cpu_resetn", 32'(cpu_resetn), 32'(exp_done));
      check("err", 32'(err), 32'(exp_err));
      check("word_count", 32'(word_count), 32'(exp_cnt));
      check("wstrb", 32'(m_wstrb), 32'hF);
      if (m_awvalid && exp_q.size() > 0) check("awaddr", 32'(m_awaddr), exp_q[0].addr % (32'd1 << AW));
      if (m_wvalid && exp_q.size() > 0) check("wdata", m_wdata, exp_q[0].data);
      if (in_valid && in_ready) begin
         if (img_idx >= img_q.size()) begin
            check("extra_accept", 32'd1, 32'd0);
         end else begin
            w = img_q[img_idx];
            img_idx++;
            if (first_acc < 0) first_acc = cyc;
            if (word_ok(w.addr)) begin
               exp_q.push_back(w);
            end else begin
               exp_err = 1'b1;
               if (w.last) exp_done = 1'b1;
            end
         end
      end
      if (m_awvalid && m_awready) begin
         if (exp_q.size() == 0 || aw_seen) check("aw_unexpected", 32'd1, 32'd0);
         else aw_seen = 1'b1;
      end
      if (m_wvalid && m_wready) begin
         if (exp_q.size() == 0 || w_seen) check("w_unexpected", 32'd1, 32'd0);
         else w_seen = 1'b1;
      end
      if (m_wvalid && w_block > 0) w_block--;
      if (m_bvalid && m_bready) begin
         if (!pending) begin
            check("b_unexpected", 32'd1, 32'd0);
         end else begin
            if (m_bresp == 2'b00) exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
            else exp_err = 1'b1;
            if (exp_q[0].last) exp_done = 1'b1;
            void'(exp_q.pop_front());
            pending = 1'b0;
         end
      end
      if (aw_seen && w_seen && !pending) begin
         pending = 1'b1; aw_seen = 1'b0; w_seen = 1'b0;
      end
   endtask

   // Feed the image until the model says loading is over, then dwell in DONE.
   task automatic run_image(input string tag, input int budget, input int want_cnt, input int want_err);
      int n;
      n = 0;
      img_idx = 0;
      while (!(exp_done && img_idx >= img_q.size()) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check({tag, "_timeout"}, 32'd1, 32'd0);
      repeat (4) tick();
      check({tag, "_final_done"}, 32'(done), 32'd1);
      check({tag, "_final_cpu_resetn"}, 32'(cpu_resetn), 32'd1);
      if (want_cnt >= 0) check({tag, "_final_count"}, 32'(word_count), 32'(want_cnt));
      if (want_err >= 0) check({tag, "_final_err"}, 32'(err), 32'(want_err));
   endtask

   initial begin
      int n;
      int nw;
      logic [31:0] a;
      resetn = 1'b1;
      model_reset();
      set_slave(100, 100, 100, 0, 0, 100);

      // Three back-to-back words with an always-ready slave.
      do_reset();
      img_q.delete();
      add_word(32'h0, $urandom, 1'b0);
      add_word(32'h4, $urandom, 1'b0);
      add_word(32'h8, $urandom, 1'b1);
      run_image("three", 60, 3, 0);
      check("three_done_latency", 32'(done_cyc - first_acc), 32'd9);

      // W stalled for five cycles while AW completes immediately.
      do_reset();
      img_q.delete();
      w_block = 5;
      add_word(32'h100, 32'hCAFE_F00D, 1'b1);
      run_image("wstall", 60, 1, 0);

      // Out-of-range word dropped, then a valid last word.
      do_reset();
      img_q.delete();
      add_word(32'h0002_0000, $urandom, 1'b0);
      add_word(32'h10, $urandom, 1'b1);
      run_image("range", 60, 1, 1);

      // Misaligned last word: no traffic, straight to DONE.
      do_reset();
      img_q.delete();
      add_word(32'h6, $urandom, 1'b1);
      run_image("misalign", 30, 0, 1);

      // Slave error responses.
      do_reset();
      img_q.delete();
      set_slave(100, 100, 100, 100, 0, 100);
      add_word(32'h20, $urandom, 1'b0);
      add_word(32'h24, $urandom, 1'b1);
      run_image("bresp", 60, 0, 1);

      // Reset while AW is outstanding, then a clean load.
      do_reset();
      img_q.delete();
      set_slave(0, 100, 100, 0, 0, 100);
      add_word(32'h40, $urandom, 1'b1);
      img_idx = 0;
      n = 0;
      while (!m_awvalid && n < 10) begin
         tick();
         n++;
      end
      check("midrst_awvalid", 32'(m_awvalid), 32'd1);
      do_reset();
      img_q.delete();
      set_slave(100, 100, 100, 0, 0, 100);
      add_word(32'h44, $urandom, 1'b0);
      add_word(32'h48, $urandom, 1'b1);
      run_image("after_rst", 60, 2, 0);

      // Counter saturation.
      do_reset();
      img_q.delete();
      for (int i = 0; i < 9; i++) add_word(32'(i * 4), $urandom, 1'(i == 8));
      run_image("saturate", 200, CNT_MAX, 0);

      // Random images against a random slave.
      for (int it = 0; it < 8; it++) begin
         do_reset();
         img_q.delete();
         set_slave($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                   $urandom_range(0, 20), $urandom_range(0, 30), $urandom_range(30, 100));
         nw = $urandom_range(1, 12);
         for (int i = 0; i < nw; i++) begin
            if ($urandom_range(0, 9) < 7) a = {15'd0, 15'($urandom), 2'b00};
            else a = $urandom;
            add_word(a, $urandom, 1'(i == nw - 1));
         end
         run_image("random", 2000, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/zverif_loader.md
ZVERIF_LOADER -- requirements
Module: zverif_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the byte-address width of the RAM load port.
REQ-002 Parameter MAX_COUNT_WIDTH, default 16, SHALL set the width of word_count.
REQ-003 clk  input  1  clock; all logic SHALL be on posedge clk.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  load-word stream handshake.
REQ-006 in_addr  input  32  byte address of load word.
REQ-007 in_data  input  32  load word.
REQ-008 in_last  input  1  marks final word of image.
REQ-009 m_awaddr  output  ADDR_WIDTH  AXI-lite write address to RAM port B.
REQ-010 m_awvalid / m_awready  output / input  1 / 1  AW handshake.
REQ-011 m_wdata  output  32  write data; m_wstrb output 4, SHALL be constant 4'hF.
REQ-012 m_wvalid / m_wready  output / input  1 / 1  W handshake.
REQ-013 m_bvalid / m_bready  input / output  1 / 1  B handshake; m_bresp input 2.
REQ-014 cpu_resetn  output  1  CPU reset release.
REQ-015 done  output  1  image fully loaded.
REQ-016 err  output  1  sticky error flag.
REQ-017 word_count  output  MAX_COUNT_WIDTH  words successfully written.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, RESP, DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; a word is accepted on in_valid && in_ready.
REQ-020 On accept, addr/data/last SHALL be latched; valid word (in_addr[1:0]==0 and in_addr < 2^ADDR_WIDTH) -> WRITE next cycle.
REQ-021 Invalid word SHALL be dropped (no AXI traffic), err set, word_count unchanged; next state DONE if in_last else IDLE.
REQ-022 In WRITE, m_awvalid and m_wvalid SHALL both assert the cycle after accept, each deasserting the cycle after its own handshake; order of AW vs W completion SHALL be irrelevant, including same-cycle.
REQ-023 m_awaddr/m_wdata SHALL hold stable while the corresponding valid is high.
REQ-024 When both AW and W have handshaken -> RESP; m_bready SHALL be 1 only in RESP.
REQ-025 On m_bvalid in RESP: word_count increments (saturating at all-ones); m_bresp != 2'b00 sets err and SHALL still count the word as issued but not increment word_count; next DONE if latched last else IDLE.
REQ-026 Minimum throughput with always-ready slave: accept cycle N, AW/W handshake N+1, B at N+2, in_ready again at N+3.
REQ-027 DONE SHALL be terminal until reset: done=1, cpu_resetn=1, in_ready=0, no AXI valids.
REQ-028 cpu_resetn SHALL be registered and equal to (state==DONE) delayed by zero cycles relative to done; it SHALL never glitch high before DONE.
REQ-029 err SHALL be sticky until reset and SHALL NOT prevent reaching DONE.
REQ-030 m_bvalid outside RESP SHALL be ignored.

Reset
REQ-031 While resetn=0 at a clk edge: state IDLE, in_ready=0 during reset then 1 first cycle after, m_awvalid=m_wvalid=m_bready=0, done=0, cpu_resetn=0, err=0, word_count=0.
REQ-032 Reset asserted mid-WRITE or mid-RESP SHALL abort the transfer without completing it; outstanding handshakes are discarded.

Verification
REQ-033 Three valid words 0x0,0x4,0x8 (last on 0x8), slave always ready -> three writes, word_count=3, done=1 and cpu_resetn=1 by cycle 9 after first accept.
REQ-034 m_wready held 0 for 5 cycles while m_awready=1 -> AW completes first, m_wvalid held with stable data, single write completes, word_count=1.
REQ-035 Word at in_addr=0x0002_0000 (ADDR_WIDTH=17) then valid word at 0x10 with last -> first dropped, err=1, one write, word_count=1, done=1.
REQ-036 Misaligned in_addr=0x6 with in_last=1 -> no AXI traffic, err=1, done=1, word_count=0.
REQ-037 m_bresp=2'b10 on a write -> err=1, word_count not incremented, FSM continues.
REQ-038 resetn pulsed low while m_awvalid=1 -> next cycle all outputs at reset values; a subsequent load completes normally.
